// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial two's-complement subtractor, LSB first (optional SERIAL_SUB_OVF_EN adds ovf)
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
    output logic             ovf,
`endif
    output logic             bout
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_sh, b_sh, r_sh;
    logic [CW-1:0]    cnt;
    logic             bin;
    logic             accept, last, x, y, d, bnx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        last     = 1'b0;
        x        = a_sh[0];
        y        = b_sh[0];
        d        = x ^ y ^ bin;
        bnx      = (~x & y) | (~(x ^ y) & bin);
        case (state)
            IDLE: begin
                accept = start;
                if (start) state_nx = SHIFT;
            end
            SHIFT: begin
                last = (cnt == LAST);
                if (cnt == LAST) state_nx = DONE;
            end
            DONE: begin
                // DONE accepts a new start exactly like IDLE for back-to-back use
                accept   = start;
                state_nx = start ? SHIFT : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh <= '0;
            b_sh <= '0;
            r_sh <= '0;
            bin  <= 1'b0;
            cnt  <= '0;
            diff <= '0;
            bout <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf  <= 1'b0;
`endif
        end else if (accept) begin
            a_sh <= a;
            b_sh <= b;
            r_sh <= '0;
            bin  <= 1'b0;
            cnt  <= '0;
        end else if (state == SHIFT) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            r_sh <= {d, r_sh[WIDTH-1:1]};
            bin  <= bnx;
            cnt  <= cnt + CW'(1);
            if (last) begin
                diff <= {d, r_sh[WIDTH-1:1]};
                bout <= bnx;
`ifdef SERIAL_SUB_OVF_EN
                // x and y are the latched operand MSBs on the final bit
                ovf  <= (x != y) && (d != x);
`endif
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - randomized self-checking bench for serial_subtractor (WIDTH=8)
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       busy, done, bout;
    logic [7:0] diff;
`ifdef SERIAL_SUB_OVF_EN
    logic       ovf;
`endif

    int n_cmp = 0;
    int n_mis = 0;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
`ifdef SERIAL_SUB_OVF_EN
        .ovf   (ovf),
`endif
        .bout  (bout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // called at a negedge; returns after the accepting edge E0
    task automatic launch(input logic [7:0] x, input logic [7:0] y);
        start = 1'b1;
        a     = x;
        b     = y;
        @(posedge clk);
    endtask

    // follows one operation to its done cycle; returns at the negedge inside DONE
    task automatic finish_op(input logic [7:0] x, input logic [7:0] y, input bit hold,
                             input bit scramble, output int n);
        int         busy_n, overlap, sd;
        logic [7:0] exp_d;
        busy_n  = 0;
        overlap = 0;
        n       = 0;
        do begin
            @(negedge clk);
            n++;
            if (!hold) start = 1'b0;
            if (scramble) begin
                a = 8'($urandom);
                b = 8'($urandom);
            end
            if (busy) busy_n++;
            if (busy && done) overlap++;
        end while (!done && n < 40);
        exp_d = x - y;
        sd    = int'($signed(x)) - int'($signed(y));
        check("latency", n - 1, 8);
        check("busy_cycles", busy_n, 8);
        check("busy_done_overlap", overlap, 0);
        check("diff", diff, exp_d);
        check("bout", bout, (x < y) ? 1 : 0);
`ifdef SERIAL_SUB_OVF_EN
        check("ovf", ovf, (sd > 127 || sd < -128) ? 1 : 0);
`else
        if (sd > 1000) $display("note: unreachable %0d", sd);
`endif
        start = 1'b0;
    endtask

    initial begin
        int         n;
        logic [7:0] x, y, last_d;
        int         gap;

        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_diff", diff, 0);
        check("rst_bout", bout, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", busy, 0);

        launch(8'h05, 8'h03); finish_op(8'h05, 8'h03, 0, 0, n);
        @(negedge clk);
        launch(8'h03, 8'h05); finish_op(8'h03, 8'h05, 0, 0, n);
        @(negedge clk);
        launch(8'h00, 8'h01); finish_op(8'h00, 8'h01, 0, 0, n);
        @(negedge clk);
        launch(8'h80, 8'h01); finish_op(8'h80, 8'h01, 0, 0, n);
        @(negedge clk);
        launch(8'h10, 8'h20); finish_op(8'h10, 8'h20, 0, 0, n);
        @(negedge clk);
        launch(8'h3C, 8'h3C); finish_op(8'h3C, 8'h3C, 0, 0, n);

        repeat (3) @(negedge clk);
        check("hold_diff", diff, 8'h00);
        check("hold_done", done, 0);

        launch(8'h9A, 8'h27); finish_op(8'h9A, 8'h27, 1, 1, n);

        launch(8'h44, 8'h45); finish_op(8'h44, 8'h45, 0, 0, n);
        check("b2b_gap", n, 9);

        @(negedge clk);
        launch(8'h12, 8'h34);
        repeat (4) @(negedge clk);
        start = 1'b0;
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_diff", diff, 0);
        check("abort_bout", bout, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        launch(8'hAA, 8'h55); finish_op(8'hAA, 8'h55, 0, 0, n);

        for (int i = 0; i < 24; i++) begin
            gap = int'($urandom_range(0, 3));
            repeat (gap) @(negedge clk);
            x = 8'($urandom);
            y = 8'($urandom);
            if (i % 8 == 0) y = x;
            launch(x, y);
            finish_op(x, y, 0, (i % 3 == 0), n);
            if (gap == 0) check("rand_b2b_gap", n, 9);
            last_d = x - y;
        end
        repeat (2) @(negedge clk);
        check("final_hold_diff", diff, last_d);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
